// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit and its address generator.
package lsu_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_e;

   // Encoding of req_is_store
   localparam logic LSU_LOAD  = 1'b0;
   localparam logic LSU_STORE = 1'b1;

endpackage

// File: rtl/lsu_agu.sv
// Address generator: ea = base + offset with 8-bit wrap, flags ea above ADDR_MAX.
// Purely combinational, no handshake; also used by branch-target logic.
module lsu_agu
   import lsu_pkg::*;
#(
   parameter int ADDR_MAX = 255
) (
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] offset_i,
   output logic [ADDR_W-1:0] ea_o,
   output logic              addr_err_o
);

   // One extra bit so ADDR_MAX = 255 compares without truncation.
   localparam logic [ADDR_W:0] ADDR_MAX_C = (ADDR_W+1)'(ADDR_MAX);

   always_comb begin
      ea_o       = base_i + offset_i;
      addr_err_o = {1'b0, ea_o} > ADDR_MAX_C;
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request at a time, response MEM_LAT+1 cycles after accept
// (error: straight to response); stalls in RESP while rsp_ready is low, req_ready only in IDLE.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_LAT  = 0,
   parameter int ADDR_MAX = 255,
   parameter int TAG_W    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [ADDR_W-1:0] req_base,
   input  logic [ADDR_W-1:0] req_offset,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_is_load,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_read_addr,
   output logic [ADDR_W-1:0] mem_write_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write,
   output logic              mem_enable,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              busy
);

   localparam logic [2:0] MEM_LAT_C = 3'(MEM_LAT);

   lsu_state_e        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] ea_q, ea_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              is_load_q, is_load_d;
   logic              err_q, err_d;
   logic              first_q, first_d;

   logic [ADDR_W-1:0] agu_ea;
   logic              agu_err;

   lsu_agu #(.ADDR_MAX(ADDR_MAX)) u_agu (
      .base_i     (req_base),
      .offset_i   (req_offset),
      .ea_o       (agu_ea),
      .addr_err_o (agu_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ea_q      <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         tag_q     <= '0;
         is_load_q <= 1'b0;
         err_q     <= 1'b0;
         first_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ea_q      <= ea_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         tag_q     <= tag_d;
         is_load_q <= is_load_d;
         err_q     <= err_d;
         first_q   <= first_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ea_d       = ea_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      tag_d      = tag_q;
      is_load_d  = is_load_q;
      err_d      = err_q;
      first_d    = 1'b0;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      mem_enable = 1'b0;
      mem_write  = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               tag_d     = req_tag;
               is_load_d = (req_is_store == LSU_LOAD);
               if (agu_err) begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = RESP;
               end else begin
                  // Address/data only move on a real access so memory pins stay quiet otherwise.
                  err_d   = 1'b0;
                  ea_d    = agu_ea;
                  wdata_d = req_wdata;
                  cnt_d   = MEM_LAT_C;
                  first_d = 1'b1;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            mem_enable = 1'b1;
            mem_write  = first_q && !is_load_q;
            if (cnt_q == 3'd0) begin
               rdata_d = is_load_q ? mem_read_data : '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_read_addr  = ea_q;
   assign mem_write_addr = ea_q;
   assign mem_write_data = wdata_q;
   assign rsp_rdata      = rdata_q;
   assign rsp_tag        = tag_q;
   assign rsp_is_load    = is_load_q;
   assign rsp_err        = err_q;
   assign busy           = (state_q != IDLE);

endmodule
